// File: rtl/up3_if.sv
// Control/status bundle between the UP3 control unit (master) and the datapath (slave).
// Carries the control strobes, the program-load write port, and the datapath state
// returned to the controller (pc, opcode, value, ac, mem_data, zero, carry).
interface up3_if;
    logic       load_ac;
    logic       load_iru;
    logic       load_irl;
    logic       load_pc;
    logic       incr_pc;
    logic       fetch;
    logic       store_mem;
    logic       prog_we;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] pc;
    logic [7:0] opcode;
    logic [7:0] value;
    logic [7:0] ac;
    logic [7:0] mem_data;
    logic       zero;
    logic       carry;

    modport master (
        output load_ac, load_iru, load_irl, load_pc, incr_pc, fetch, store_mem,
        output prog_we, prog_addr, prog_data,
        input  pc, opcode, value, ac, mem_data, zero, carry
    );

    modport slave (
        input  load_ac, load_iru, load_irl, load_pc, incr_pc, fetch, store_mem,
        input  prog_we, prog_addr, prog_data,
        output pc, opcode, value, ac, mem_data, zero, carry
    );
endinterface

// File: rtl/up3_datapath.sv
// UP3 datapath: PC, IR (opcode/value), accumulator, carry flag and a 256x8
// program/data memory, driven by per-cycle strobes from the control unit.
// Ports: clk, reset (sync, active-high), bus (up3_if.slave: strobes,
// program-load port, and returned state pc/opcode/value/ac/mem_data/zero/carry).
module up3_datapath (
    input  logic clk,
    input  logic reset,
    up3_if.slave bus
);
    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned AW        = 8;
    localparam int unsigned DW        = 8;

    localparam logic [DW-1:0] OP_LDI = 8'h01;
    localparam logic [DW-1:0] OP_LDA = 8'h02;
    localparam logic [DW-1:0] OP_ADD = 8'h03;
    localparam logic [DW-1:0] OP_SUB = 8'h04;
    localparam logic [DW-1:0] OP_AND = 8'h05;
    localparam logic [DW-1:0] OP_OR  = 8'h06;
    localparam logic [DW-1:0] OP_XOR = 8'h07;

    logic [DW-1:0] mem [MEM_DEPTH];

    logic [AW-1:0] pc_q;
    logic [DW-1:0] opcode_q;
    logic [DW-1:0] value_q;
    logic [DW-1:0] ac_q;
    logic [DW-1:0] mem_data_q;
    logic          carry_q;

    logic [AW-1:0] rd_addr;
    logic [DW:0]   sum;
    logic [DW:0]   diff;
    logic [DW-1:0] ac_nxt;
    logic          carry_nxt;

    assign rd_addr = bus.fetch ? pc_q : AW'(value_q);

    // ALU: decoded from the registered opcode, so a same-cycle load_iru cannot affect it.
    always_comb begin
        ac_nxt    = ac_q;
        carry_nxt = carry_q;
        sum       = {1'b0, ac_q} + {1'b0, mem_data_q};
        diff      = {1'b0, ac_q} - {1'b0, mem_data_q};
        case (opcode_q)
            OP_LDI: ac_nxt = value_q;
            OP_LDA: ac_nxt = mem_data_q;
            OP_ADD: begin
                ac_nxt    = sum[DW-1:0];
                carry_nxt = sum[DW];
            end
            OP_SUB: begin
                ac_nxt    = diff[DW-1:0];
                carry_nxt = diff[DW];   // borrow out of the 9-bit subtraction
            end
            OP_AND: ac_nxt = ac_q & mem_data_q;
            OP_OR:  ac_nxt = ac_q | mem_data_q;
            OP_XOR: ac_nxt = ac_q ^ mem_data_q;
            default: ;
        endcase
    end

    // Memory write port: program load beats a store; nothing is written during reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (bus.prog_we) begin
                mem[bus.prog_addr] <= bus.prog_data;
            end else if (bus.store_mem) begin
                mem[AW'(value_q)] <= ac_q;
            end
        end
    end

    // Synchronous read; non-blocking update gives old data on a same-address write.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_data_q <= '0;
        end else begin
            mem_data_q <= mem[rd_addr];
        end
    end

    // Architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= '0;
            opcode_q <= '0;
            value_q  <= '0;
            ac_q     <= '0;
            carry_q  <= 1'b0;
        end else begin
            if (bus.load_pc) begin
                pc_q <= AW'(value_q);
            end else if (bus.incr_pc) begin
                pc_q <= pc_q + AW'(1);
            end
            if (bus.load_iru) opcode_q <= mem_data_q;
            if (bus.load_irl) value_q  <= mem_data_q;
            if (bus.load_ac) begin
                ac_q    <= ac_nxt;
                carry_q <= carry_nxt;
            end
        end
    end

    assign bus.pc       = DW'(pc_q);
    assign bus.opcode   = opcode_q;
    assign bus.value    = value_q;
    assign bus.ac       = ac_q;
    assign bus.mem_data = mem_data_q;
    assign bus.carry    = carry_q;
    assign bus.zero     = (ac_q == '0);

endmodule

// File: tb/tb_up3_datapath.sv
// Directed self-checking bench for up3_datapath.
module tb_up3_datapath;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    up3_if bus ();

    up3_datapath dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.load_ac   = 1'b0;
        bus.load_iru  = 1'b0;
        bus.load_irl  = 1'b0;
        bus.load_pc   = 1'b0;
        bus.incr_pc   = 1'b0;
        bus.fetch     = 1'b0;
        bus.store_mem = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = 8'h00;
        bus.prog_data = 8'h00;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic prog(input logic [7:0] addr, input logic [7:0] data);
        clr();
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        step();
        clr();
    endtask

    // Two-byte instruction fetch at pc: fetch; load_iru+incr; fetch; load_irl+incr.
    task automatic fetch_instr();
        clr(); bus.fetch = 1'b1;                      step();
        clr(); bus.load_iru = 1'b1; bus.incr_pc = 1'b1; step();
        clr(); bus.fetch = 1'b1;                      step();
        clr(); bus.load_irl = 1'b1; bus.incr_pc = 1'b1; step();
        clr();
    endtask

    // Operand read at value, then load_ac using it.
    task automatic exec_mem();
        clr();                   step();
        clr(); bus.load_ac = 1'b1; step();
        clr();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr();
        reset = 1'b1;
        step();
        reset = 1'b0;
        prog(8'h00, 8'hAB);

        // Reset with random strobes, including writes aimed at mem[0].
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.load_ac   = 1'($urandom);
            bus.load_iru  = 1'($urandom);
            bus.load_irl  = 1'($urandom);
            bus.load_pc   = 1'($urandom);
            bus.incr_pc   = 1'($urandom);
            bus.fetch     = 1'($urandom);
            bus.store_mem = 1'b1;
            bus.prog_we   = (i % 2 == 0);
            bus.prog_addr = 8'h00;
            bus.prog_data = 8'h55;
            step();
        end
        clr();
        chk("rst_pc",       bus.pc,        8'h00);
        chk("rst_opcode",   bus.opcode,    8'h00);
        chk("rst_value",    bus.value,     8'h00);
        chk("rst_ac",       bus.ac,        8'h00);
        chk("rst_mem_data", bus.mem_data,  8'h00);
        chk("rst_carry",    8'(bus.carry), 8'h00);
        chk("rst_zero",     8'(bus.zero),  8'h01);
        reset = 1'b0;
        bus.fetch = 1'b1;
        step();
        clr();
        chk("rst_mem0_kept", bus.mem_data, 8'hAB);

        // Program image: instruction stream and data.
        prog(8'h00, 8'h03); prog(8'h01, 8'h10);   // ADD 0x10
        prog(8'h02, 8'h01); prog(8'h03, 8'hF0);   // LDI 0xF0
        prog(8'h04, 8'h03); prog(8'h05, 8'h10);   // ADD 0x10
        prog(8'h06, 8'h04); prog(8'h07, 8'h11);   // SUB 0x11
        prog(8'h08, 8'h05); prog(8'h09, 8'h12);   // AND 0x12
        prog(8'h0A, 8'h01); prog(8'h0B, 8'h5A);   // LDI 0x5A
        prog(8'h0C, 8'h00); prog(8'h0D, 8'h30);   // NOP 0x30
        prog(8'h0E, 8'h00); prog(8'h0F, 8'h42);   // NOP 0x42
        prog(8'h10, 8'h20);
        prog(8'h11, 8'h11);
        prog(8'h12, 8'h00);
        prog(8'h30, 8'h77);
        prog(8'h42, 8'h00); prog(8'h43, 8'hFF);   // NOP 0xFF

        // Fetch/decode.
        fetch_instr();
        chk("dec_opcode", bus.opcode, 8'h03);
        chk("dec_value",  bus.value,  8'h10);
        chk("dec_pc",     bus.pc,     8'h02);

        // ALU chain.
        fetch_instr();
        clr(); bus.load_ac = 1'b1; step(); clr();
        chk("ldi_ac",   bus.ac,       8'hF0);
        chk("ldi_zero", 8'(bus.zero), 8'h00);
        fetch_instr(); exec_mem();
        chk("add_ac",    bus.ac,        8'h10);
        chk("add_carry", 8'(bus.carry), 8'h01);
        fetch_instr(); exec_mem();
        chk("sub_ac",    bus.ac,        8'hFF);
        chk("sub_carry", 8'(bus.carry), 8'h01);
        fetch_instr(); exec_mem();
        chk("and_ac",    bus.ac,        8'h00);
        chk("and_zero",  8'(bus.zero),  8'h01);
        chk("and_carry", 8'(bus.carry), 8'h01);

        // Store, read-during-write, and prog_we/store conflict.
        fetch_instr();
        clr(); bus.load_ac = 1'b1; step(); clr();
        chk("ldi5a_ac", bus.ac, 8'h5A);
        fetch_instr();
        chk("st_value", bus.value, 8'h30);
        clr(); bus.store_mem = 1'b1; step(); clr();
        chk("st_rdw_old", bus.mem_data, 8'h77);
        step();
        chk("st_mem30", bus.mem_data, 8'h5A);
        bus.store_mem = 1'b1;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 8'h30;
        bus.prog_data = 8'h11;
        step(); clr();
        chk("conf_rdw_old", bus.mem_data, 8'h5A);
        step();
        chk("conf_mem30", bus.mem_data, 8'h11);

        // PC corners.
        fetch_instr();
        chk("pc_pre_jump", bus.pc, 8'h10);
        clr(); bus.load_pc = 1'b1; bus.incr_pc = 1'b1; step(); clr();
        chk("pc_jump_prio", bus.pc, 8'h42);
        fetch_instr();
        clr(); bus.load_pc = 1'b1; step(); clr();
        chk("pc_ff", bus.pc, 8'hFF);
        bus.incr_pc = 1'b1; step(); clr();
        chk("pc_wrap", bus.pc, 8'h00);

        // Reset in the cycle an ADD executes.
        fetch_instr();
        clr(); step();
        chk("mid_pre_ac",    bus.ac,        8'h5A);
        chk("mid_pre_carry", 8'(bus.carry), 8'h01);
        bus.load_ac = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        clr();
        chk("mid_ac",     bus.ac,        8'h00);
        chk("mid_carry",  8'(bus.carry), 8'h00);
        chk("mid_opcode", bus.opcode,    8'h00);
        chk("mid_pc",     bus.pc,        8'h00);
        bus.fetch = 1'b1; step(); clr();
        chk("mid_mem0_kept", bus.mem_data, 8'h03);
        bus.load_iru = 1'b1; step(); clr();
        chk("mid_opcode_reload", bus.opcode, 8'h03);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
